// File: rtl/uart_apb_master.sv
// Single-outstanding APB3 master: one command in, one APB transfer, one response out.
// Define UART_APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_req_wdata,
  input  logic                      i_req_write,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic                      o_rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
  output logic                      o_apb_pwrite,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pslverr,
  output logic                      o_busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;

  localparam bit TIMEOUT_OK = (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535);
  if (!TIMEOUT_OK) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
  logic        rsp_timeout_q;
  assign o_rsp_timeout = rsp_timeout_q;
`else
  assign o_rsp_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_req_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_apb_paddr   <= '0;
      o_apb_pwdata  <= '0;
      o_apb_pwrite  <= 1'b0;
      o_apb_psel    <= 1'b0;
      o_apb_penable <= 1'b0;
      o_busy        <= 1'b0;
`ifdef UART_APB_MASTER_TIMEOUT_EN
      to_cnt        <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_apb_paddr  <= i_req_addr;
            o_apb_pwdata <= i_req_wdata;
            o_apb_pwrite <= i_req_write;
            o_apb_psel   <= 1'b1;
            o_req_ready  <= 1'b0;
            o_busy       <= 1'b1;
            state        <= SETUP;
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        SETUP: begin
          o_apb_penable <= 1'b1;
          state         <= ACCESS;
`ifdef UART_APB_MASTER_TIMEOUT_EN
          to_cnt        <= '0;
`endif
        end
        ACCESS: begin
          // PREADY wins over a timeout that would fire on the same edge
          if (i_apb_pready) begin
            o_rsp_rdata   <= o_apb_pwrite ? '0 : i_apb_prdata;
            o_rsp_err     <= i_apb_pslverr;
            o_apb_psel    <= 1'b0;
            o_apb_penable <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
`ifdef UART_APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            o_apb_psel    <= 1'b0;
            o_apb_penable <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
`endif
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: expected responses queued at issue, checked by a monitor.
module tb_uart_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_write;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite, psel, penable, pready, pslverr, busy;
  logic [DW-1:0] prdata;

  // simple APB slave: ready after slv_wait ACCESS cycles unless slv_never
  int            slv_wait = 0;
  bit            slv_never = 1'b0;
  bit            slv_err = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  int            acc_cnt = 0;

  assign pready  = psel && penable && !slv_never && (acc_cnt >= slv_wait);
  assign pslverr = pready && slv_err;
  assign prdata  = slv_rdata;

  always @(posedge clk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

  always #5 clk = ~clk;

  uart_apb_master #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_write(req_write),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_apb_paddr(paddr), .o_apb_pwdata(pwdata), .o_apb_pwrite(pwrite),
    .o_apb_psel(psel), .o_apb_penable(penable),
    .i_apb_prdata(prdata), .i_apb_pready(pready), .i_apb_pslverr(pslverr),
    .o_busy(busy)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: compare every response handshake against the queue head
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        check("rsp_timeout", rsp_timeout, e.tmo);
      end
    end
  end

  // returns right after the accept edge (+1)
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                       input logic [DW-1:0] er, input logic ee, input logic et, input bit push);
    rsp_t e;
    int   n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 0, 1);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_write = w;
    e.rdata = er; e.err = ee; e.tmo = et;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;  // changes while busy must not reach PADDR
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) check(name, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) check(name, 1, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("req_ready_after_rst", req_ready, 1);

    // write, zero wait: PSEL, PENABLE, rsp_valid on successive edges
    slv_wait = 0; slv_err = 0;
    issue(32'h0000_0004, 32'hA5, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    check("w_psel_c1", psel, 1);
    check("w_penable_c1", penable, 0);
    check("w_req_ready_c1", req_ready, 0);
    check("w_busy_c1", busy, 1);
    check("w_pwdata", pwdata, 32'hA5);
    @(posedge clk); #1;
    check("w_penable_c2", penable, 1);
    check("w_psel_c2", psel, 1);
    @(posedge clk); #1;
    check("w_rsp_valid_c3", rsp_valid, 1);
    check("w_psel_c3", psel, 0);
    @(posedge clk); #1;
    check("w_rsp_valid_clr", rsp_valid, 0);
    check("w_req_ready_back", req_ready, 1);
    check("w_paddr_hold", paddr, 32'h4);
    check("w_pwrite_hold", pwrite, 1);

    // read with 3 wait states, PADDR must stay put
    slv_wait = 3; slv_rdata = 32'hDEAD_BEEF;
    issue(32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    begin
      int acc = 0;
      int n = 0;
      while (!rsp_valid && n < 50) begin
        check("r_paddr_stable", paddr, 32'h10);
        if (psel && penable) acc++;
        @(posedge clk); #1;
        n++;
      end
      check("r_access_cycles", acc, 4);
    end
    wait_idle("r_idle_wait");

    // PSLVERR read, response held 5 cycles while rsp_ready low
    slv_wait = 0; slv_err = 1; slv_rdata = 32'h1234_5678;
    rsp_ready = 1'b0;
    issue(32'h20, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    wait_rsp("e_rsp_wait");
    for (int i = 0; i < 5; i++) begin
      check("e_hold_valid", rsp_valid, 1);
      check("e_hold_err", rsp_err, 1);
      check("e_hold_rdata", rsp_rdata, 32'h1234_5678);
      check("e_hold_timeout", rsp_timeout, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_idle("e_idle_wait");
    slv_err = 0;

`ifdef UART_APB_MASTER_TIMEOUT_EN
    // slave never ready: abort after 8 ACCESS cycles, then a normal transfer
    slv_never = 1'b1;
    issue(32'h30, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    begin
      int acc = 0;
      int n = 0;
      while (!rsp_valid && n < 50) begin
        if (psel && penable) acc++;
        @(posedge clk); #1;
        n++;
      end
      check("t_access_cycles", acc, 8);
      check("t_psel_dropped", psel, 0);
    end
    wait_idle("t_idle_wait");
    slv_never = 1'b0; slv_rdata = 32'h0BAD_F00D;
    issue(32'h34, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1);
    wait_rsp("t_next_rsp_wait");
    wait_idle("t_next_idle_wait");
`endif

    // reset on the second ACCESS cycle aborts silently
    slv_never = 1'b1;
    issue(32'h40, 32'h77, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;   // first ACCESS cycle
    @(posedge clk); #1;   // second ACCESS cycle
    check("x_in_access", penable, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("x_psel", psel, 0);
    check("x_busy", busy, 0);
    check("x_rsp_valid", rsp_valid, 0);
    rst = 1'b0; slv_never = 1'b0;
    @(posedge clk); #1;
    check("x_req_ready", req_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("x_no_rsp", rsp_valid, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_apb_master.md
UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS wait cycles before abort (range 1..65535).
REQ-004 SHALL have ports, one per line:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  command valid.
- o_req_ready  out  1  command accept.
- i_req_addr  in  APB_ADDR_WIDTH  target address.
- i_req_wdata  in  APB_DATA_WIDTH  write data.
- i_req_write  in  1  1 = write, 0 = read.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accept.
- o_rsp_rdata  out  APB_DATA_WIDTH  read data; 0 for writes and aborts.
- o_rsp_err  out  1  PSLVERR seen or timeout.
- o_rsp_timeout  out  1  transfer aborted by timeout.
- o_apb_paddr  out  APB_ADDR_WIDTH  APB3 PADDR.
- o_apb_pwdata  out  APB_DATA_WIDTH  APB3 PWDATA.
- o_apb_pwrite  out  1  APB3 PWRITE.
- o_apb_psel  out  1  APB3 PSEL.
- o_apb_penable  out  1  APB3 PENABLE.
- i_apb_prdata  in  APB_DATA_WIDTH  APB3 PRDATA.
- i_apb_pready  in  1  APB3 PREADY.
- i_apb_pslverr  in  1  APB3 PSLVERR.
- o_busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, with all APB and response outputs registered.
REQ-006 IDLE: o_req_ready=1; on i_req_valid&o_req_ready, SHALL latch addr/wdata/write into PADDR/PWDATA/PWRITE and enter SETUP.
REQ-007 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS unconditionally.
REQ-008 ACCESS: PSEL=1, PENABLE=1; PADDR/PWDATA/PWRITE SHALL remain stable until PREADY is sampled high.
REQ-009 On PREADY=1 in ACCESS, SHALL capture PRDATA (reads only; writes store 0) and PSLVERR into o_rsp_rdata/o_rsp_err, drop PSEL and PENABLE at the next edge, and enter RESP.
REQ-010 RESP: o_rsp_valid=1, with rdata/err/timeout held stable until i_rsp_ready=1; on handshake SHALL clear o_rsp_valid and return to IDLE.
REQ-011 o_req_ready SHALL be 0 in SETUP, ACCESS and RESP; a single outstanding transfer only.
REQ-012 Minimum latency: accept at edge 0, PSEL at 1, PENABLE at 2, o_rsp_valid at 3 when PREADY=1 on the first ACCESS cycle and i_rsp_ready=1.
REQ-013 Back-to-back throughput SHALL be one transfer per 4 cycles minimum, since IDLE is always visited for one cycle.
REQ-014 After a transfer, PADDR/PWDATA/PWRITE SHALL hold their last values; PSEL and PENABLE SHALL be 0 outside SETUP/ACCESS.
REQ-015 Request inputs changing while o_req_ready=0 SHALL have no effect.

Reset
REQ-016 While i_rst=1 at a clock edge, SHALL enter IDLE and clear all outputs to 0, including o_req_ready, PADDR and PWDATA; o_req_ready rises the first cycle after i_rst falls.
REQ-017 Reset during SETUP/ACCESS/RESP SHALL abort without issuing a response; PSEL SHALL be 0 after that edge.

Configuration
REQ-018 With macro UART_APB_MASTER_TIMEOUT_EN defined, a counter SHALL:
- clear on entry to ACCESS;
- increment each ACCESS cycle with PREADY=0;
- on reaching TIMEOUT_CYCLES, drop PSEL/PENABLE and enter RESP with o_rsp_err=1, o_rsp_timeout=1, o_rsp_rdata=0.
PREADY sampled high takes priority over the timeout.
REQ-019 Without UART_APB_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely, the counter SHALL not exist, and o_rsp_timeout SHALL be tied to 0.

Verification
REQ-020 Write addr=0x0000_0004, wdata=0xA5, PREADY=1 immediately:
- PSEL at cycle 1, PENABLE at cycle 2, o_rsp_valid at cycle 3;
- err=0, rdata=0.
REQ-021 Read addr=0x10, PREADY low 3 ACCESS cycles, PRDATA=0xDEADBEEF:
- PADDR stable throughout;
- rsp rdata=0xDEADBEEF, err=0.
REQ-022 Read with PSLVERR=1 at PREADY: err=1, timeout=0; i_rsp_ready held low 5 cycles, so response held stable for 5 cycles.
REQ-023 Macro defined, TIMEOUT_CYCLES=8, PREADY never high:
- abort after 8 ACCESS cycles;
- err=1, timeout=1, rdata=0;
- next request accepted normally.
REQ-024 i_rst=1 asserted on the second ACCESS cycle: PSEL=0 and o_busy=0 after that edge; no o_rsp_valid; o_req_ready=1 one cycle after reset release.
